// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared CHIP-8 display constants, the scan-out FSM state type, and the
// (row, col) -> framebuffer bit index mapping used by every block that touches
// the 2048-bit display vector.
// -----------------------------------------------------------------------------
package chip8_pkg;

  localparam int DISP_W    = 64;
  localparam int DISP_H    = 32;
  localparam int DISP_BITS = DISP_W * DISP_H;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Row 0 / col 0 lives in the MSB; pixels run left-to-right, top-to-bottom
  // towards bit 0.
  function automatic logic [10:0] pix_index(input logic [4:0] row,
                                            input logic [5:0] col);
    return 11'(DISP_BITS - 1 - int'(row) * DISP_W - int'(col));
  endfunction

endpackage

// File: rtl/chip8_display_scanout_if.sv
// -----------------------------------------------------------------------------
// chip8_display_scanout_if
// Pixel stream from the framebuffer scan-out to the video/panel driver.
//   pix_valid / pix_ready : beat handshake (transfer when both high)
//   pix_data              : pixel value, 1 = lit
//   pix_x / pix_y         : source column 0..63 / source row 0..31
//   pix_sof/eol/eof       : first beat of frame / last of line / last of frame
// master = scan-out (source), slave = video driver (sink).
// -----------------------------------------------------------------------------
interface chip8_display_scanout_if;

  logic       pix_valid;
  logic       pix_ready;
  logic       pix_data;
  logic [5:0] pix_x;
  logic [4:0] pix_y;
  logic       pix_sof;
  logic       pix_eol;
  logic       pix_eof;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/chip8_scan_counter.sv
// -----------------------------------------------------------------------------
// chip8_scan_counter
// Nested raster counters for the scan-out, innermost first:
//   hrep (0..SCALE-1) -> col (0..63) -> vrep (0..SCALE-1) -> row (0..31)
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : return all counters to zero (frame start)
//   adv_i      : advance by one beat
//   col_o/row_o: current source column / row
//   sof_o      : all counters at zero
//   eol_o      : last beat of an output line
//   eof_o      : last beat of the frame
// -----------------------------------------------------------------------------
module chip8_scan_counter
  import chip8_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       adv_i,
  output logic [5:0] col_o,
  output logic [4:0] row_o,
  output logic       sof_o,
  output logic       eol_o,
  output logic       eof_o
);

  // Replication counters are 3 bits so SCALE up to 8 fits; with SCALE=1 they
  // stay at 0 and every beat advances col.
  localparam logic [2:0] REP_LAST = 3'(SCALE - 1);

  logic [2:0] hrep_q, hrep_d;
  logic [5:0] col_q,  col_d;
  logic [2:0] vrep_q, vrep_d;
  logic [4:0] row_q,  row_d;

  logic col_last;
  logic row_last;

  assign col_last = (col_q == 6'(DISP_W - 1));
  assign row_last = (row_q == 5'(DISP_H - 1));

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first so
    // no path through the ifs below leaves it unassigned (no inferred latch).
    hrep_d = hrep_q;
    col_d  = col_q;
    vrep_d = vrep_q;
    row_d  = row_q;
    if (clr_i) begin
      hrep_d = '0;
      col_d  = '0;
      vrep_d = '0;
      row_d  = '0;
    end else if (adv_i) begin
      if (hrep_q != REP_LAST) begin
        hrep_d = hrep_q + 3'd1;
      end else begin
        hrep_d = '0;
        if (!col_last) begin
          col_d = col_q + 6'd1;
        end else begin
          col_d = '0;
          if (vrep_q != REP_LAST) begin
            vrep_d = vrep_q + 3'd1;
          end else begin
            vrep_d = '0;
            // Only the eof beat carries row past 31; it wraps to 0, which is
            // harmless because the frame has ended.
            row_d  = row_q + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      hrep_q <= '0;
      col_q  <= '0;
      vrep_q <= '0;
      row_q  <= '0;
    end else begin
      hrep_q <= hrep_d;
      col_q  <= col_d;
      vrep_q <= vrep_d;
      row_q  <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;
  assign sof_o = (hrep_q == '0) && (col_q == '0) && (vrep_q == '0) && (row_q == '0);
  assign eol_o = col_last && (hrep_q == REP_LAST);
  assign eof_o = eol_o && row_last && (vrep_q == REP_LAST);

endmodule

// File: rtl/chip8_display_scanout.sv
// -----------------------------------------------------------------------------
// chip8_display_scanout
// Snapshots the CHIP-8 framebuffer on a start request and streams it out one
// pixel per beat, optionally replicating each pixel SCALE x SCALE.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (rst beats start)
//   start       : frame request, honoured only while idle
//   display_in  : 2048-bit framebuffer, pixel (r,c) at bit 2047 - r*64 - c
//   busy        : a frame is being streamed
//   frame_done  : one-cycle pulse the cycle after the eof beat transfers
//   pix         : pixel stream (master side)
// -----------------------------------------------------------------------------
module chip8_display_scanout
  import chip8_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DISP_BITS-1:0] display_in,
  output logic                 busy,
  output logic                 frame_done,
  chip8_display_scanout_if.master pix
);

  state_t               state_q;
  logic [DISP_BITS-1:0] snap_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 done_q;

  logic       start_acc;
  logic       xfer;
  logic [5:0] col;
  logic [4:0] row;
  logic       sof_c;
  logic       eol_c;
  logic       eof_c;

  assign start_acc = (state_q == IDLE) && start;
  assign xfer      = valid_q && pix.pix_ready;

  chip8_scan_counter #(
    .SCALE (SCALE)
  ) u_scan_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_acc),
    .adv_i (xfer),
    .col_o (col),
    .row_o (row),
    .sof_o (sof_c),
    .eol_o (eol_c),
    .eof_o (eof_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the snapshot is a plain register bank, so it can be cleared on
      // reset; this keeps pix_data at a known 0 before the first frame.
      snap_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q  <= display_in;
            state_q <= STREAM;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        STREAM: begin
          // start is deliberately not looked at here: no queueing of requests.
          if (xfer && eof_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The counters sit at zero while idle, so the framing flags and the pixel
  // value are qualified with valid to keep them low outside a frame.
  assign pix.pix_valid = valid_q;
  assign pix.pix_data  = valid_q & snap_q[pix_index(row, col)];
  assign pix.pix_x     = col;
  assign pix.pix_y     = row;
  assign pix.pix_sof   = valid_q & sof_c;
  assign pix.pix_eol   = valid_q & eol_c;
  assign pix.pix_eof   = valid_q & eof_c;

  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/chip8_display_scanout.md
Name: chip8_display_scanout

Overview:
- Reader side of the CHIP-8 framebuffer.
- `chip8_display` writes sprite rows into the 2048-bit display vector; this block snapshots that vector on request and streams it out pixel by pixel.
- Output is a valid/ready stream with coordinate and framing sideband, feeding the video/panel driver.
- Optional integer upscaling repeats each pixel SCALE times horizontally and each row SCALE times vertically.

Parameters:
- SCALE, 1, integer pixel replication factor in x and y; legal 1..8.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a frame scan; sampled only in IDLE
- display_in  in  2048  framebuffer; pixel (row r, col c) = bit 2047 - r*64 - c; 1 = lit
- busy  out  1  high while a frame is being streamed
- pix_valid  out  1  output beat valid
- pix_ready  in  1  downstream accepts beat
- pix_data  out  1  pixel value of the current beat
- pix_x  out  6  source column 0..63 of the current beat
- pix_y  out  5  source row 0..31 of the current beat
- pix_sof  out  1  first beat of the frame
- pix_eol  out  1  last beat of an output line
- pix_eof  out  1  last beat of the frame
- frame_done  out  1  one-cycle pulse after the last beat transfers

Behaviour:
- Reset: state IDLE; snapshot cleared to 0.
- Reset output values: busy=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_sof=0, pix_eol=0, pix_eof=0, frame_done=0.
- Reset mid-frame aborts the frame; no frame_done is produced.
- FSM states:
  - IDLE: start=1 → snapshot <= display_in; all counters <= 0; go to STREAM.
  - STREAM: emits beats; goes to IDLE on the final transfer.
- Latency: with start high at cycle N, busy=1 and pix_valid=1 at N+1, first beat is (x=0, y=0).
- Snapshot isolation: display_in changes after the start cycle do not affect the frame being streamed.
- Handshake:
  - A transfer occurs on a cycle with pix_valid && pix_ready.
  - While pix_valid && !pix_ready, all pix_* outputs hold stable.
  - pix_valid never drops mid-frame.
- Counters (all advance only on transfer), order from innermost:
  - hrep 0..SCALE-1;
  - col 0..63;
  - vrep 0..SCALE-1;
  - row 0..31.
- Beat fields:
  - pix_x = col, pix_y = row;
  - pix_data = snapshot bit for (row, col), read directly from the snapshot register (no extra latency).
- Beat counts:
  - each output line = 64*SCALE beats;
  - each source row is emitted as SCALE identical lines;
  - total beats per frame = 2048*SCALE*SCALE.
- Framing flags:
  - pix_sof = row==0 && vrep==0 && col==0 && hrep==0;
  - pix_eol = col==63 && hrep==SCALE-1;
  - pix_eof = pix_eol && row==31 && vrep==SCALE-1.
- Completion: the cycle after the eof transfer has busy=0, pix_valid=0, frame_done=1 for exactly one cycle.
- start in STREAM is ignored; there is no queueing.
- start in the frame_done cycle is accepted, since the FSM is already IDLE.
- start and rst in the same cycle: rst wins.
- SCALE=1: hrep and vrep are constant 0; each beat advances col.
- Counter wrap: col wraps 63→0 and increments the next level; row never wraps within a frame.

Decomposition:
- chip8_pkg holds:
  - DISP_W=64, DISP_H=32, DISP_BITS=2048;
  - state enum {IDLE, STREAM};
  - function pix_index(row, col) = DISP_BITS-1 - row*DISP_W - col, shared with chip8_display.
- One sub-module, chip8_scan_counter: nested hrep/col/vrep/row counters with an advance enable.
  - Outputs: col, row, sof, eol, eof.
  - Parameterised by SCALE.
- The top level holds the FSM, the snapshot register, the pixel mux and frame_done.

Test Plan:
- Reset, then idle with start=0 → busy=0, pix_valid=0, frame_done=0 for 20 cycles.
- SCALE=1; display_in has row 0 cols 4..7 lit (as after a 0xF0 draw at x=4, y=0); start pulse, pix_ready=1.
  - 2048 beats; pix_data=1 exactly at beats 4..7.
  - sof on beat 0, eol every 64th beat, eof on beat 2047.
  - frame_done on the next cycle; total 2049 cycles from start to frame_done.
- Backpressure: pix_ready toggled pseudo-randomly; bench reconstructs the framebuffer.
  - Reconstruction equals display_in.
  - Outputs stable on every stalled cycle.
- Snapshot isolation: flip display_in to all-ones the cycle after start → streamed frame is still the original.
- SCALE=2; single lit pixel at (x=63, y=31) → 8192 beats, exactly 4 with pix_data=1, the last being the eof beat.
- Reset mid-frame at beat 1000 → pix_valid=0 next cycle, no frame_done. Then start during STREAM (ignored), and a fresh start after reset → a full frame.
